mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator-side load/store unit driving the word-only DataMem port (rd, wr, addr, wdata, rdata).
//  Turns CPU byte/half/word load and store requests into word-aligned memory cycles.
//  Sub-word stores use a read-modify-write sequence.
//  Sits between the multi-cycle datapath's MEM stage and the data memory.
// PARAMETERS
//  RAM_SIZE  16  number of 32-bit words in the attached memory; word index >= RAM_SIZE is an error
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept; 1 only in IDLE
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00=byte, 01=half, 10=word, 11=illegal
//  req_signed  in   1   loads: sign-extend sub-word result
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified for byte/half
//  resp_valid  out  1   one-cycle pulse; request complete
//  resp_rdata  out  32  load result, held until next response
//  resp_err    out  1   misaligned/illegal/out-of-range, valid with resp_valid
//  mem_rd      out  1   memory read enable
//  mem_wr      out  1   memory write enable (memory writes at posedge clk)
//  mem_addr    out  32  {addr[31:2],2'b00}
//  mem_wdata   out  32  merged write word
//  mem_rdata   in   32  combinational read data from memory
// BEHAVIOUR
//  - Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0; req_ready=1.
//  - Accept on posedge when req_valid&&req_ready; latch we/size/signed/addr/wdata.
//    req_valid while busy is ignored, not queued.
//  - Error check at accept: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2]>=RAM_SIZE.
//    On error -> RESP directly, no mem_rd/mem_wr ever asserted, resp_rdata unchanged.
//  - FSM states: IDLE, RD, WR, RESP.
//    IDLE -> RESP on error; -> WR for store word; -> RD for any load or byte/half store.
//    RD: mem_rd=1; mem_rdata captured at the edge leaving RD. Load -> RESP with extracted data. Store -> WR.
//    WR: mem_wr=1, mem_wdata=merged word -> RESP.
//    RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
//  - Outputs are Moore-decoded from state. mem_rd/mem_wr/mem_addr/mem_wdata are 0 in IDLE and RESP.
//  - Latency from the accept edge to the resp_valid cycle:
//    error 1; load 2; store word 2; store byte/half 3 (RD+WR).
//  - Little-endian lanes: byte lane=addr[1:0] (lane0=[7:0]); half lane=addr[1] (0=[15:0], 1=[31:16]).
//  - Load extract: selected lane right-justified, sign- or zero-extended per req_signed; word loads ignore req_signed.
//  - Store merge: the read word with only the selected lane replaced by req_wdata[7:0]/[15:0]; other bytes preserved bit-exact.
//  - Reset mid-operation: return to IDLE asynchronously and drop mem_wr at once. Memory is either untouched or fully written (single write edge). No resp_valid for the aborted request.
// STRUCTURE
//  - Shared package: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding, RAM_SIZE default.
//  - One sub-module: mem_lane_align, combinational. Takes word, addr[1:0], size, signed, wdata; outputs load_data and merged_word.
// TESTING
//  1 reset held, then released -> all outputs 0, req_ready=1; no mem_rd/mem_wr for 5 idle cycles.
//  2 SW 0xDEADBEEF @0x08 -> one WR cycle (mem_addr=0x08, mem_wdata=0xDEADBEEF); resp_valid 2 cycles after accept, err=0.
//  3 SB 0x5A @0x09 -> RD cycle @0x08, then WR with 0xDEAD5AEF; resp at +3. Then LW @0x08 -> resp_rdata=0xDEAD5AEF.
//  4 From (3): LB @0x0B -> 0xFFFFFFDE; LBU @0x0B -> 0x000000DE; LH @0x0A -> 0xFFFFDEAD; LHU @0x08 -> 0x00005AEF.
//  5 LH @0x09, SW @0x0A, size=11, LW @0x40 (index 16) -> each resp_err=1 at +1, no mem_rd/mem_wr, resp_rdata unchanged.
//  6 SH 0x1234 @0x0C, reset asserted during RD -> mem_wr never rises, state IDLE, no resp_valid; later LW @0x0C shows the old value.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store unit: access size codes, FSM state encoding,
// default memory depth and the request error check.
package mem_access_unit_pkg;

  localparam int RAM_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Misaligned, illegal size, or word index beyond the attached memory.
  function automatic logic req_error(input size_e size, input logic [31:0] addr,
                                     input int unsigned ram_size);
    logic bad_align;
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    return bad_align || ({2'b00, addr[31:2]} >= ram_size);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide data memory port of the load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts a sub-word load result and merges
// sub-word store data into a full memory word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_sel    = word[{lane, 3'b000} +: 8];
    half_sel    = lane[1] ? word[31:16] : word[15:0];
    load_data   = word;
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
        merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sgn & half_sel[15]}}, half_sel};
        merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-aligned
// DataMem cycles, using read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_SIZE = RAM_SIZE_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  state_e      state, state_nx;
  logic        we_q;
  logic        sgn_q;
  size_e       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        accept;
  logic        err_in;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept = bus.req_valid && (state == IDLE);
  assign err_in = req_error(size_e'(bus.req_size), bus.req_addr, RAM_SIZE);

  // In RD the live memory word feeds extraction; in WR the captured word feeds the merge.
  assign align_word = (state == RD) ? bus.mem_rdata : word_q;

  mem_lane_align u_align (
    .word        (align_word),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .sgn         (sgn_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (err_in)                                          state_nx = RESP;
        else if (bus.req_we && size_e'(bus.req_size) == SZ_WORD) state_nx = WR;
        else                                                 state_nx = RD;
      end
      RD:      state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q           <= 1'b0;
      sgn_q          <= 1'b0;
      size_q         <= SZ_BYTE;
      addr_q         <= '0;
      wdata_q        <= '0;
      word_q         <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q         <= bus.req_we;
        sgn_q        <= bus.req_signed;
        size_q       <= size_e'(bus.req_size);
        addr_q       <= bus.req_addr;
        wdata_q      <= bus.req_wdata;
        bus.resp_err <= err_in;
      end
      if (state == RD) begin
        word_q <= bus.mem_rdata;
        if (!we_q) bus.resp_rdata <= load_data;
      end
    end
  end

  // Moore outputs; the memory port is quiet outside RD/WR so reset drops mem_wr at once.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.mem_rd     = (state == RD);
    bus.mem_wr     = (state == WR);
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (state == RD || state == WR) bus.mem_addr = {addr_q[31:2], 2'b00};
    if (state == WR)                bus.mem_wdata = merged_word;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single requests plus
// hand-written reset and abort sequences against a 16-word memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.RAM_SIZE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:15];
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    int          nrd;
    int          nwr;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [31:0] wword;
  } vec_t;

  int          res_lat;
  logic [31:0] res_rdata;
  logic        res_err;
  int          res_nrd;
  int          res_nwr;
  logic [31:0] res_raddr;
  logic [31:0] res_waddr;
  logic [31:0] res_wdata;

  // Issues one request and watches the unit until resp_valid, bounded to 8 cycles.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    res_lat = -1; res_nrd = 0; res_nwr = 0; res_err = 1'bx;
    res_rdata = 'x; res_raddr = 'x; res_waddr = 'x; res_wdata = 'x;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_rd) begin res_nrd++; res_raddr = bus.mem_addr; end
      if (bus.mem_wr) begin res_nwr++; res_waddr = bus.mem_addr; res_wdata = bus.mem_wdata; end
      if (bus.resp_valid) begin
        res_lat = c; res_rdata = bus.resp_rdata; res_err = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_flags"}, 32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_rd, bus.mem_wr}),
          32'b10000);
    check({name, "_addr"}, bus.mem_addr, 32'h0);
    check({name, "_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  vec_t v [18];
  logic seen;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    //        we   sz    sg   addr         wdata         lat err nrd nwr chk  rdata         wword
    v[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 2, 1'b0, 0, 1, 1'b0, 32'h0,        32'hDEADBEEF};
    v[1]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'hFFFFFF5A, 3, 1'b0, 1, 1, 1'b0, 32'h0,        32'hDEAD5AEF};
    v[2]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'hDEAD5AEF, 32'h0};
    v[3]  = '{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'hFFFFFFDE, 32'h0};
    v[4]  = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'h000000DE, 32'h0};
    v[5]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'hFFFFDEAD, 32'h0};
    v[6]  = '{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'h00005AEF, 32'h0};
    v[7]  = '{1'b0, 2'd1, 1'b1, 32'h09, 32'h0,        1, 1'b1, 0, 0, 1'b1, 32'h00005AEF, 32'h0};
    v[8]  = '{1'b1, 2'd2, 1'b0, 32'h0A, 32'h12345678, 1, 1'b1, 0, 0, 1'b1, 32'h00005AEF, 32'h0};
    v[9]  = '{1'b0, 2'd3, 1'b0, 32'h08, 32'h0,        1, 1'b1, 0, 0, 1'b1, 32'h00005AEF, 32'h0};
    v[10] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        1, 1'b1, 0, 0, 1'b1, 32'h00005AEF, 32'h0};
    v[11] = '{1'b1, 2'd1, 1'b0, 32'h0E, 32'h5555BEEF, 3, 1'b0, 1, 1, 1'b0, 32'h0,        32'hBEEF0000};
    v[12] = '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'hFFFFBEEF, 32'h0};
    v[13] = '{1'b1, 2'd2, 1'b0, 32'h3C, 32'h11223344, 2, 1'b0, 0, 1, 1'b0, 32'h0,        32'h11223344};
    v[14] = '{1'b0, 2'd1, 1'b1, 32'h3C, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'h00003344, 32'h0};
    v[15] = '{1'b0, 2'd2, 1'b1, 32'h3C, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'h11223344, 32'h0};
    v[16] = '{1'b1, 2'd0, 1'b0, 32'h3F, 32'h00000080, 3, 1'b0, 1, 1, 1'b0, 32'h0,        32'h80223344};
    v[17] = '{1'b0, 2'd0, 1'b1, 32'h3F, 32'h0,        2, 1'b0, 1, 0, 1'b1, 32'hFFFFFF80, 32'h0};

    // Reset held, then released: quiet outputs, ready, no memory activity.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    check("reset_rdata", bus.resp_rdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_outputs("idle_after_reset");
    end

    foreach (v[i]) begin
      run_req(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata);
      check($sformatf("v%0d_latency", i), 32'(res_lat), 32'(v[i].lat));
      check($sformatf("v%0d_err", i), 32'(res_err), 32'(v[i].err));
      check($sformatf("v%0d_nrd", i), 32'(res_nrd), 32'(v[i].nrd));
      check($sformatf("v%0d_nwr", i), 32'(res_nwr), 32'(v[i].nwr));
      if (v[i].chk_rd) check($sformatf("v%0d_rdata", i), res_rdata, v[i].rdata);
      if (v[i].nrd > 0) check($sformatf("v%0d_raddr", i), res_raddr, {v[i].addr[31:2], 2'b00});
      if (v[i].nwr > 0) begin
        check($sformatf("v%0d_waddr", i), res_waddr, {v[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_wword", i), res_wdata, v[i].wword);
      end
    end

    // Request while busy: unit not ready during RD, and the busy request is dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 32'h08; bus.req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("busy_ready_low", 32'(bus.req_ready), 32'h0);
    bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_resp", 32'({bus.resp_valid, bus.resp_err}), 32'b10);
    check("busy_rdata", bus.resp_rdata, 32'hDEAD5AEF);
    repeat (3) @(negedge clk);
    check("busy_not_queued", mem[12], 32'h0);

    // SH aborted by reset during RD: no write, no response, memory keeps old word.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0C; bus.req_wdata = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_in_rd", 32'(bus.mem_rd), 32'h1);
    check("abort_rd_addr", bus.mem_addr, 32'h0C);
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      if (bus.mem_wr || bus.resp_valid) seen = 1'b1;
    end
    check("abort_no_wr_resp", 32'(seen), 32'h0);
    check("abort_mem_kept", mem[3], 32'hBEEF0000);
    run_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    check("abort_lw_latency", 32'(res_lat), 32'd2);
    check("abort_lw_rdata", res_rdata, 32'hBEEF0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
